// File: rtl/maze_pkg.sv
// Shared constants, state encoding and coordinate helpers for the depth-first maze solver.
package maze_pkg;

    localparam int N     = 16;
    localparam int CW    = 4;
    localparam int DEPTH = N * N;
    localparam int AW    = $clog2(DEPTH);
    localparam int SPW   = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] GOAL = CW'(N - 1);

    localparam logic [1:0] DIR_XP = 2'd0;
    localparam logic [1:0] DIR_YP = 2'd1;
    localparam logic [1:0] DIR_XN = 2'd2;
    localparam logic [1:0] DIR_YN = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHK0,
        S_CHK0_S,
        S_MARK,
        S_PROBE,
        S_SAMPLE,
        S_NEXT,
        S_MOVE,
        S_POP,
        S_STREAM,
        S_FAIL
    } state_t;

    // One extra bit per axis so stepping off either edge is visible as >= N.
    typedef struct packed {
        logic [CW:0] x;
        logic [CW:0] y;
    } coord_t;

    function automatic coord_t step(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                    input logic [1:0] d);
        coord_t c;
        c.x = {1'b0, x};
        c.y = {1'b0, y};
        case (d)
            DIR_XP:  c.x = c.x + (CW+1)'(1);
            DIR_YP:  c.y = c.y + (CW+1)'(1);
            DIR_XN:  c.x = c.x - (CW+1)'(1);
            default: c.y = c.y - (CW+1)'(1);
        endcase
        return c;
    endfunction

    function automatic logic in_bounds(input coord_t c);
        return (c.x < (CW+1)'(N)) && (c.y < (CW+1)'(N));
    endfunction

    // Undo a stacked move; the result is always on the grid, so CW bits suffice.
    function automatic logic [2*CW-1:0] retreat(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                                input logic [1:0] d);
        logic [CW-1:0] rx;
        logic [CW-1:0] ry;
        rx = x;
        ry = y;
        case (d)
            DIR_XP:  rx = x - CW'(1);
            DIR_YP:  ry = y - CW'(1);
            DIR_XN:  rx = x + CW'(1);
            default: ry = y + CW'(1);
        endcase
        return {rx, ry};
    endfunction

endpackage

// File: rtl/maze_solver_move_stack.sv
// LIFO of 2-bit move directions with an indexed read port used both for pops and path streaming.
module move_stack #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           srst,
    input  logic           clear,
    input  logic           push,
    input  logic           pop,
    input  logic [1:0]     push_dir,
    input  logic [AW-1:0]  rd_addr,
    output logic [1:0]     rd_dir,
    output logic [SPW-1:0] sp
);

    logic [1:0]     stack_mem [DEPTH];
    logic [SPW-1:0] sp_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            sp_reg <= '0;
        end else if (push) begin
            sp_reg <= sp_reg + SPW'(1);
        end else if (pop && (sp_reg != '0)) begin
            sp_reg <= sp_reg - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            stack_mem[sp_reg[AW-1:0]] <= push_dir;
        end
    end

    assign rd_dir = stack_mem[rd_addr];
    assign sp     = sp_reg;

endmodule

// File: rtl/maze_solver.sv
// Depth-first rat-in-maze controller: marks visited cells in maze_memory, backtracks via
// a move stack, and streams the found path as direction codes.
module maze_solver
    import maze_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [CW-1:0] mem_x,
    output logic [CW-1:0] mem_y,
    output logic          mem_din,
    input  logic          mem_dout,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic          move_valid,
    output logic [1:0]    move_dir
);

    state_t         state_reg, state_next;
    logic [CW-1:0]  cur_x_reg, cur_x_next;
    logic [CW-1:0]  cur_y_reg, cur_y_next;
    logic [1:0]     d_reg, d_next;
    logic [SPW-1:0] idx_reg, idx_next;
    logic           done_reg, done_next;
    logic           fail_reg, fail_next;

    logic           st_push, st_pop, st_clear;
    logic [AW-1:0]  st_addr;
    logic [1:0]     st_dir;
    logic [SPW-1:0] sp;

    coord_t          nb;
    logic            nb_ok, nb_goal;
    logic [2*CW-1:0] back;

    assign nb      = step(cur_x_reg, cur_y_reg, d_reg);
    assign nb_ok   = in_bounds(nb);
    assign nb_goal = (nb.x == {1'b0, GOAL}) && (nb.y == {1'b0, GOAL});
    assign back    = retreat(cur_x_reg, cur_y_reg, st_dir);

    // POP reads the top entry; otherwise the port walks the stack for streaming.
    assign st_addr = (state_reg == S_POP) ? (sp[AW-1:0] - AW'(1)) : idx_reg[AW-1:0];

    move_stack #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .SPW   (SPW)
    ) u_stack (
        .clk      (clk),
        .srst     (rst),
        .clear    (st_clear),
        .push     (st_push),
        .pop      (st_pop),
        .push_dir (d_reg),
        .rd_addr  (st_addr),
        .rd_dir   (st_dir),
        .sp       (sp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cur_x_reg <= '0;
            cur_y_reg <= '0;
            d_reg     <= '0;
            idx_reg   <= '0;
            done_reg  <= 1'b0;
            fail_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cur_x_reg <= cur_x_next;
            cur_y_reg <= cur_y_next;
            d_reg     <= d_next;
            idx_reg   <= idx_next;
            done_reg  <= done_next;
            fail_reg  <= fail_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cur_x_next = cur_x_reg;
        cur_y_next = cur_y_reg;
        d_next     = d_reg;
        idx_next   = idx_reg;
        done_next  = done_reg;
        fail_next  = fail_reg;
        st_push    = 1'b0;
        st_pop     = 1'b0;
        st_clear   = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_x      = '0;
        mem_y      = '0;
        move_valid = 1'b0;
        move_dir   = 2'd0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    done_next  = 1'b0;
                    fail_next  = 1'b0;
                    cur_x_next = '0;
                    cur_y_next = '0;
                    d_next     = '0;
                    st_clear   = 1'b1;
                    state_next = S_CHK0;
                end
            end
            S_CHK0: begin
                mem_rd     = 1'b1;
                state_next = S_CHK0_S;
            end
            S_CHK0_S:  state_next = mem_dout ? S_FAIL : S_MARK;
            S_MARK: begin
                mem_wr     = 1'b1;
                mem_x      = cur_x_reg;
                mem_y      = cur_y_reg;
                d_next     = '0;
                state_next = S_PROBE;
            end
            S_PROBE: begin
                if (nb_ok) begin
                    mem_rd     = 1'b1;
                    mem_x      = nb.x[CW-1:0];
                    mem_y      = nb.y[CW-1:0];
                    state_next = S_SAMPLE;
                end else begin
                    state_next = S_NEXT;
                end
            end
            S_SAMPLE:  state_next = mem_dout ? S_NEXT : S_MOVE;
            S_NEXT: begin
                if (d_reg != DIR_YN) begin
                    d_next     = d_reg + 2'd1;
                    state_next = S_PROBE;
                end else begin
                    state_next = S_POP;
                end
            end
            S_MOVE: begin
                st_push    = 1'b1;
                cur_x_next = nb.x[CW-1:0];
                cur_y_next = nb.y[CW-1:0];
                if (nb_goal) begin
                    idx_next   = '0;
                    state_next = S_STREAM;
                end else begin
                    state_next = S_MARK;
                end
            end
            S_POP: begin
                if (sp == '0) begin
                    state_next = S_FAIL;
                end else begin
                    st_pop     = 1'b1;
                    cur_x_next = back[2*CW-1:CW];
                    cur_y_next = back[CW-1:0];
                    // A popped -y move has no untried directions left, so keep popping.
                    if (st_dir != DIR_YN) begin
                        d_next     = st_dir + 2'd1;
                        state_next = S_PROBE;
                    end
                end
            end
            S_STREAM: begin
                move_valid = 1'b1;
                move_dir   = st_dir;
                idx_next   = idx_reg + SPW'(1);
                if ((idx_reg + SPW'(1)) >= sp) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_FAIL: begin
                fail_next  = 1'b1;
                state_next = S_IDLE;
            end
            default:   state_next = S_IDLE;
        endcase
    end

    assign busy    = (state_reg != S_IDLE);
    assign done    = done_reg;
    assign fail    = fail_reg;
    assign mem_din = 1'b1;

endmodule
